ifetch_buffer: RTL and testbench
================================

Name: ifetch_buffer

Overview:
- Sits directly downstream of the instruction fetch unit.
- Takes the fetch PC stream, issues in-order instruction memory reads and pairs each returned instruction word with its PC.
- Buffers up to DEPTH fetches, counting both in-flight and returned entries, and presents them in order to decode with a valid/ready handshake.
- A flush input discards all buffered and in-flight fetches on a pipeline redirect.

Parameters:
- DEPTH, 4, number of buffer entries and maximum in-flight fetches; power of 2, >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_i  input  32  fetch address from the fetch unit.
- pc_valid_i  input  1  pc_i is valid.
- pc_ready_o  output  1  pc_i accepted this cycle (memory granted).
- imem_req_o  output  1  instruction memory read request.
- imem_addr_o  output  32  read address, equal to pc_i.
- imem_gnt_i  input  1  memory accepts the request this cycle.
- imem_rvalid_i  input  1  read data valid; responses return in request order.
- imem_rdata_i  input  32  instruction word.
- flush_i  input  1  discard all buffered and in-flight fetches.
- inst_valid_o  output  1  head entry holds a returned instruction.
- inst_ready_i  input  1  decode consumes the head entry.
- inst_o  output  32  head instruction word.
- inst_pc_o  output  32  PC of the head instruction.

Behaviour:
- Storage: circular buffer of DEPTH entries, each holding {pc[31:0], inst[31:0], filled}.
  - Three pointers: alloc_ptr, fill_ptr, head_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - alloc_cnt, 0..DEPTH, width log2(DEPTH)+1, counts allocated entries (filled or not).
- Request (combinational):
  - imem_req_o = pc_valid_i & ~rst & ~flush_i & (alloc_cnt < DEPTH) & (drop_cnt == 0).
  - imem_addr_o = pc_i, unmodified; low bits are passed through.
  - pc_ready_o = imem_req_o & imem_gnt_i.
- Allocate: when pc_ready_o=1, write pc_i to entry[alloc_ptr] with filled=0; alloc_ptr+1.
- Fill:
  - When imem_rvalid_i=1 and drop_cnt==0: write imem_rdata_i to entry[fill_ptr], set filled=1; fill_ptr+1.
  - An rvalid with no unfilled entry is a protocol violation: ignored, no state change; the bench flags it with an assertion.
- Output:
  - inst_valid_o = entry[head_ptr].filled & (alloc_cnt != 0) & ~flush_i.
  - inst_o and inst_pc_o are driven from entry[head_ptr].
  - Pop when inst_valid_o & inst_ready_i: clear filled, head_ptr+1.
- alloc_cnt next value = alloc_cnt + allocate - pop. Allocate, fill and pop may all occur in the same cycle; sustained throughput is 1 instruction/cycle.
- Latency:
  - Grant in cycle N allows rvalid in N+1 at the earliest.
  - rvalid in cycle M into the head entry gives inst_valid_o=1 in cycle M+1. There is no same-cycle bypass.
- Full: alloc_cnt==DEPTH forces imem_req_o=0, pc_ready_o=0. A pop in the same cycle frees the slot only from the next cycle; the credit check uses the registered count.
- Flush (flush_i=1 in cycle F):
  - All entries are invalidated at the end of F; pointers are set equal to each other; alloc_cnt <= 0.
  - drop_cnt <= unfilled_cnt - imem_rvalid_i, where unfilled_cnt is the number of allocated-but-unfilled entries. Any response arriving in F is itself discarded.
  - While drop_cnt != 0, every rvalid decrements drop_cnt and writes nothing; requests stay blocked.
  - flush_i is honoured whatever the fill state; a second flush during draining recomputes nothing, because drop_cnt already covers all in-flight responses.
- Reset: synchronous on rst, taking effect at the clock edge.
  - All pointers, alloc_cnt and drop_cnt go to 0; all filled flags go to 0; entry data goes to 0.
  - Resulting outputs: inst_valid_o=0, inst_o=0, inst_pc_o=0, pc_ready_o=0, imem_req_o=0.
  - Reset mid-operation abandons in-flight fetches without drop accounting; the memory must be reset together with this block.

Test Plan:
- Streaming: memory gnt=1 every cycle with rvalid 1 cycle after each grant; PCs 0x0,0x4,0x8,...; inst_ready_i=1 -> after the first 2 cycles, one instruction per cycle with inst_pc_o 0x0,0x4,0x8 in order and inst_o matching memory data.
- Back-pressure: inst_ready_i=0, DEPTH=4 -> exactly 4 grants (PCs 0x0..0xC), then imem_req_o=0; raise ready -> entries 0x0..0xC drain in order and requests resume the cycle after the first pop.
- Variable latency: rvalid delays of 3,1,5 cycles for PCs 0x10,0x14,0x18 -> output order 0x10,0x14,0x18 with correct data; inst_valid_o never high for an unfilled head.
- Flush with 2 in flight: grant 0x20,0x24, assert flush before either response -> drop_cnt=2, both later responses discarded, no inst_valid_o; next PC 0x100 is issued only after the second discard and is output with its own data.
- Flush coinciding with rvalid: 3 in flight, rvalid in the flush cycle -> drop_cnt=2; exactly 2 further responses dropped.
- Reset mid-stream: assert rst with 3 buffered entries -> next cycle inst_valid_o=0, inst_o=0, inst_pc_o=0, imem_req_o=0, alloc_cnt=0.

Source files
------------

// File: rtl/ifetch_buffer.sv
// Instruction fetch buffer: issues in-order instruction memory reads for the
// fetch PC stream, pairs each returned word with its PC, and hands entries to
// decode in order. Entries are allocated at grant time so the buffer also
// bounds the number of reads in flight. A flush discards everything; responses
// still in flight at that point are counted and silently dropped on arrival.
module ifetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        pc_valid_i,
  output logic        pc_ready_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        flush_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] alloc_ptr;
  logic [AW-1:0] fill_ptr;
  logic [AW-1:0] head_ptr;
  logic [CW-1:0] alloc_cnt;
  logic [CW-1:0] unfilled_cnt;  // allocated entries still waiting for data
  logic [CW-1:0] drop_cnt;      // responses owed to fetches killed by a flush

  logic [31:0] pc_arr     [DEPTH];
  logic [31:0] inst_arr   [DEPTH];
  logic        filled_arr [DEPTH];

  logic alloc_en;
  logic fill_en;
  logic pop_en;
  logic drop_en;
  logic resp_taken;

  // Request gating, output presentation and per-cycle event strobes.
  always_comb begin
    imem_req_o   = pc_valid_i & ~rst & ~flush_i & (alloc_cnt < FULL) & (drop_cnt == '0);
    imem_addr_o  = pc_i;
    pc_ready_o   = imem_req_o & imem_gnt_i;
    inst_valid_o = filled_arr[head_ptr] & (alloc_cnt != '0) & ~flush_i;
    inst_o       = inst_arr[head_ptr];
    inst_pc_o    = pc_arr[head_ptr];
    alloc_en     = pc_ready_o;
    pop_en       = inst_valid_o & inst_ready_i;
    // A response with nothing outstanding is ignored entirely.
    fill_en      = imem_rvalid_i & ~flush_i & (drop_cnt == '0) & (unfilled_cnt != '0);
    drop_en      = imem_rvalid_i & (drop_cnt != '0);
    // Any response that corresponds to a real outstanding read (live or dropped).
    resp_taken   = imem_rvalid_i & ((drop_cnt != '0) | (unfilled_cnt != '0));
  end

  // Pointers and occupancy counters; a flush folds live in-flight reads into drop_cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr    <= '0;
      fill_ptr     <= '0;
      head_ptr     <= '0;
      alloc_cnt    <= '0;
      unfilled_cnt <= '0;
      drop_cnt     <= '0;
    end else if (flush_i) begin
      alloc_ptr    <= '0;
      fill_ptr     <= '0;
      head_ptr     <= '0;
      alloc_cnt    <= '0;
      unfilled_cnt <= '0;
      // While draining unfilled_cnt is already zero, so this only keeps counting down.
      drop_cnt     <= drop_cnt + unfilled_cnt - CW'(resp_taken);
    end else begin
      if (alloc_en) alloc_ptr <= alloc_ptr + AW'(1);
      if (fill_en)  fill_ptr  <= fill_ptr + AW'(1);
      if (pop_en)   head_ptr  <= head_ptr + AW'(1);
      alloc_cnt    <= alloc_cnt + CW'(alloc_en) - CW'(pop_en);
      unfilled_cnt <= unfilled_cnt + CW'(alloc_en) - CW'(fill_en);
      if (drop_en)  drop_cnt  <= drop_cnt - CW'(1);
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [31:0] entry_pc;
    logic [31:0] entry_inst;
    logic        entry_filled;

    // One buffer slot: PC written at allocation, word and filled flag at fill.
    always_ff @(posedge clk) begin
      if (rst) begin
        entry_pc     <= '0;
        entry_inst   <= '0;
        entry_filled <= 1'b0;
      end else if (flush_i) begin
        entry_filled <= 1'b0;
      end else begin
        if (alloc_en && (alloc_ptr == AW'(gi))) begin
          entry_pc     <= pc_i;
          entry_filled <= 1'b0;
        end
        if (fill_en && (fill_ptr == AW'(gi))) begin
          entry_inst   <= imem_rdata_i;
          entry_filled <= 1'b1;
        end
        if (pop_en && (head_ptr == AW'(gi))) begin
          entry_filled <= 1'b0;
        end
      end
    end

    assign pc_arr[gi]     = entry_pc;
    assign inst_arr[gi]   = entry_inst;
    assign filled_arr[gi] = entry_filled;
  end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Scoreboard bench for ifetch_buffer: a behavioural memory answers grants after
// a per-request latency, grants push the expected PC into a queue, and a
// negedge monitor pops and compares whenever decode consumes an entry.
module tb_ifetch_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        pc_valid = 1'b0;
  logic        pc_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt = 1'b1;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        flush = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  ifetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_i(pc), .pc_valid_i(pc_valid), .pc_ready_o(pc_ready),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .flush_i(flush),
    .inst_valid_o(inst_valid), .inst_ready_i(inst_ready), .inst_o(inst), .inst_pc_o(inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];
  int tests = 0, fails = 0, cyc = 0;
  int next_lat = 1, drop_exp = 0, drops_seen = 0, last_drop_cyc = 0, last_grant_cyc = 0;
  int pop_count = 0, first_pop_cyc = 0, last_pop_cyc = 0;

  // Instruction word the memory holds at a given address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'hC0DE_0000 ^ {a[15:0], a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Memory: answers in request order once each request's latency has elapsed.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    rvalid = 1'b0;
    rdata  = 32'hBAD0_BAD0;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      rvalid = 1'b1;
      rdata  = word_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
  end

  // Monitor: scoreboard pops, grant bookkeeping, flush/drop tracking.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mem_q.delete();
      drop_exp = 0;
    end else begin
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pop: got pc %h inst %h, required no output (cycle %0d)", inst_pc, inst, cyc);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("pop_pc", inst_pc, e);
          check("pop_inst", inst, word_of(e));
        end
        if (pop_count == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        pop_count++;
      end
      if (drop_exp > 0 && pc_valid) check("req_blocked_while_draining", 32'(imem_req), 32'd0);
      if (imem_req) check("imem_addr", imem_addr, pc);
      if (pc_ready) begin
        mem_q.push_back('{addr: pc, due: cyc + next_lat});
        exp_q.push_back(pc);
        last_grant_cyc = cyc;
      end
      if (flush) begin
        exp_q.delete();
        drop_exp = mem_q.size();
      end else if (rvalid && drop_exp > 0) begin
        drop_exp--;
        drops_seen++;
        last_drop_cyc = cyc;
      end
    end
  end

  // A response with nothing outstanding would be a memory protocol violation.
  always @(negedge clk) begin
    if (!rst && rvalid && dut.drop_cnt == '0)
      assert (dut.unfilled_cnt != '0) else $error("protocol: rvalid with no outstanding fetch");
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary line");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one PC until granted, then drop pc_valid at the next edge.
  task automatic issue(input logic [31:0] a, input int lat);
    bit ok = 0;
    next_lat = lat;
    pc       = a;
    pc_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pc_ready) ok = 1;
      tick();
      if (ok) break;
    end
    pc_valid = 1'b0;
    if (!ok) check("issue_timeout", a, 32'hFFFF_FFFF);
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && mem_q.size() == 0 && drop_exp == 0) begin
        done = 1;
        break;
      end
      tick();
    end
    if (!done) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int g0;
    // Reset with a valid PC present: nothing may be requested.
    pc_valid = 1'b1;
    pc       = 32'h0000_0ABC;
    tick();
    @(negedge clk);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_pc_ready", 32'(pc_ready), 32'd0);
    tick();
    rst      = 1'b0;
    pc_valid = 1'b0;
    tick();

    // Streaming: one grant per cycle, latency 1, decode always ready.
    inst_ready = 1'b1;
    pop_count  = 0;
    issue(32'h0, 1);
    g0 = last_grant_cyc;
    for (int k = 1; k < 8; k++) issue(32'(k * 4), 1);
    drain();
    check("stream_pops", 32'(pop_count), 32'd8);
    check("stream_first_latency", 32'(first_pop_cyc - g0), 32'd2);
    check("stream_throughput", 32'(last_pop_cyc - first_pop_cyc), 32'd7);

    // Back-pressure: four grants fill the buffer, then requests stop.
    inst_ready = 1'b0;
    pop_count  = 0;
    for (int k = 0; k < 4; k++) issue(32'(k * 4), 1);
    pc       = 32'h10;
    pc_valid = 1'b1;
    next_lat = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("full_blocks_req", 32'(imem_req), 32'd0);
      tick();
    end
    @(negedge clk);
    check("full_alloc_cnt", 32'(dut.alloc_cnt), 32'd4);
    tick();
    inst_ready = 1'b1;
    @(negedge clk);
    check("bp_head_valid", 32'(inst_valid), 32'd1);
    check("bp_no_req_on_pop_cycle", 32'(imem_req), 32'd0);
    tick();
    @(negedge clk);
    check("bp_req_resumes", 32'(imem_req), 32'd1);
    tick();
    pc_valid = 1'b0;
    drain();
    check("bp_pops", 32'(pop_count), 32'd5);

    // Variable latency 3,1,5: order and data must follow request order.
    pop_count = 0;
    issue(32'h10, 3);
    issue(32'h14, 1);
    issue(32'h18, 5);
    drain();
    check("varlat_pops", 32'(pop_count), 32'd3);

    // Flush with two reads in flight and no response yet.
    pop_count  = 0;
    drops_seen = 0;
    issue(32'h20, 4);
    issue(32'h24, 4);
    flush = 1'b1;
    @(negedge clk);
    check("flush_hides_valid", 32'(inst_valid), 32'd0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush2_drop_cnt", 32'(dut.drop_cnt), 32'd2);
    tick();
    issue(32'h100, 1);
    check("flush2_drops_seen", 32'(drops_seen), 32'd2);
    check("flush2_resume_cycle", 32'(last_grant_cyc), 32'(last_drop_cyc + 1));
    drain();
    check("flush2_pops", 32'(pop_count), 32'd1);

    // Flush in the same cycle as the first of three responses.
    pop_count  = 0;
    drops_seen = 0;
    issue(32'h30, 3);
    issue(32'h34, 3);
    issue(32'h38, 3);
    flush = 1'b1;
    @(negedge clk);
    check("flush3_rvalid_in_flush", 32'(rvalid), 32'd1);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush3_drop_cnt", 32'(dut.drop_cnt), 32'd2);
    tick();
    drain();
    check("flush3_drops_seen", 32'(drops_seen), 32'd2);
    check("flush3_drop_cnt_done", 32'(dut.drop_cnt), 32'd0);
    issue(32'h200, 1);
    drain();
    check("flush3_pops", 32'(pop_count), 32'd1);

    // Reset with three buffered entries.
    inst_ready = 1'b0;
    issue(32'h40, 1);
    issue(32'h44, 1);
    issue(32'h48, 1);
    tick();
    tick();
    @(negedge clk);
    check("pre_rst_valid", 32'(inst_valid), 32'd1);
    check("pre_rst_alloc_cnt", 32'(dut.alloc_cnt), 32'd3);
    tick();
    rst      = 1'b1;
    pc_valid = 1'b1;
    pc       = 32'h50;
    @(negedge clk);
    check("rst_mid_req", 32'(imem_req), 32'd0);
    tick();
    rst      = 1'b0;
    pc_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_mid_inst", inst, 32'd0);
    check("rst_mid_inst_pc", inst_pc, 32'd0);
    check("rst_mid_imem_req", 32'(imem_req), 32'd0);
    check("rst_mid_alloc_cnt", 32'(dut.alloc_cnt), 32'd0);
    tick();
    inst_ready = 1'b1;
    pop_count  = 0;
    issue(32'h60, 1);
    drain();
    check("post_rst_pops", 32'(pop_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
